// File: rtl/instr_cache_if.sv
// Instruction cache bus bundle: the CPU fetch side plus the block-fill side to instruction memory.
// Latency: none (wires only).
// Backpressure: BUSYWAIT stalls the fetch side; MEM_BUSYWAIT stalls the fill side.
interface instr_cache_if #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 3
);
    logic [31:0]                    PC;
    logic [31:0]                    INSTRUCTION;
    logic                           BUSYWAIT;
    logic                           MEM_READ;
    logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS;
    logic [127:0]                   MEM_READDATA;
    logic                           MEM_BUSYWAIT;

    // Cache side of the bundle
    modport slave (
        input  PC, MEM_READDATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

    // Environment side: PC stage and instruction memory
    modport master (
        output PC, MEM_READDATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache, 4-word lines held in registers.
// Latency: hit 0 cycles; miss k+3 cycles after the miss edge for k memory busy cycles.
// Backpressure: BUSYWAIT stalls the PC stage; MEM_BUSYWAIT holds the fill in MEM_READ.
module instr_cache #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    instr_cache_if.slave bus
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_READ,
        ST_UPDATE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tags [LINES];
    logic [127:0]          data [LINES];

    logic [INDEX_BITS-1:0] miss_index;
    logic [TAG_BITS-1:0]   miss_tag;
    logic [127:0]          fill_buf;

    logic [INDEX_BITS-1:0] pc_index;
    logic [TAG_BITS-1:0]   pc_tag;
    logic [1:0]            pc_offset;
    logic                  hit;
    logic                  busywait;
    logic                  mem_read;

    assign pc_offset = bus.PC[3:2];
    assign pc_index  = bus.PC[INDEX_BITS+3:4];
    assign pc_tag    = bus.PC[TAG_BITS+INDEX_BITS+3:INDEX_BITS+4];
    assign hit       = valid[pc_index] && (tags[pc_index] == pc_tag);

    assign bus.INSTRUCTION = data[pc_index][{pc_offset, 5'b00000} +: 32];
    assign bus.MEM_ADDRESS = {miss_tag, miss_index};
    assign bus.BUSYWAIT    = busywait;
    assign bus.MEM_READ    = mem_read;

    // Next-state and handshake outputs; reset overrides everything so no request leaks out
    always_comb begin
        state_nxt = state;
        busywait  = 1'b0;
        mem_read  = 1'b0;
        case (state)
            ST_IDLE: begin
                busywait = !hit;
                if (!hit) begin
                    state_nxt = ST_MEM_READ;
                end
            end
            ST_MEM_READ: begin
                busywait = 1'b1;
                mem_read = 1'b1;
                if (!bus.MEM_BUSYWAIT) begin
                    state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                busywait  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                busywait  = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
        if (RESET) begin
            busywait  = 1'b1;
            mem_read  = 1'b0;
            state_nxt = ST_IDLE;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Miss registers latch the missing line once; the fill buffer takes the block on the completing edge
    always_ff @(posedge CLK) begin
        if (RESET) begin
            miss_index <= '0;
            miss_tag   <= '0;
            fill_buf   <= '0;
        end else begin
            if (state == ST_IDLE && !hit) begin
                miss_index <= pc_index;
                miss_tag   <= pc_tag;
            end
            if (state == ST_MEM_READ && !bus.MEM_BUSYWAIT) begin
                fill_buf <= bus.MEM_READDATA;
            end
        end
    end

    // Valid bits: cleared by reset, set when the latched line is written
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid <= '0;
        end else if (state == ST_UPDATE) begin
            valid[miss_index] <= 1'b1;
        end
    end

    // Tag and data arrays are only meaningful under a valid bit, so they carry no reset value
    always_ff @(posedge CLK) begin
        if (!RESET && state == ST_UPDATE) begin
            tags[miss_index] <= miss_tag;
            data[miss_index] <= fill_buf;
        end
    end
endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: memory model with programmable busy cycles,
// queues of expected instructions and expected block addresses.
module tb_instr_cache;
    logic CLK;
    logic RESET;

    int checks;
    int errors;
    int mem_lat;

    logic [31:0] exp_q [$];
    logic [5:0]  addr_q [$];

    instr_cache_if bus ();

    instr_cache dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    function automatic logic [127:0] block_of(input logic [5:0] a);
        logic [31:0] base;
        base = {22'd0, a, 4'd0};
        return {base + 32'd12, base + 32'd8, base + 32'd4, base};
    endfunction

    // Instruction memory: busy for mem_lat cycles per request, then presents the block
    initial begin
        bit in_req;
        int busy_cnt;
        logic [5:0] ea;
        in_req = 0;
        busy_cnt = 0;
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = '0;
        forever begin
            @(negedge CLK);
            if (bus.MEM_READ === 1'b1) begin
                if (!in_req) begin
                    in_req = 1;
                    busy_cnt = 0;
                    checks++;
                    if (addr_q.size() == 0) begin
                        errors++;
                        $display("FAIL mem_request: unexpected request for block 0x%0h, required no request", bus.MEM_ADDRESS);
                    end else begin
                        ea = addr_q.pop_front();
                        if (bus.MEM_ADDRESS !== ea) begin
                            errors++;
                            $display("FAIL mem_address: got 0x%0h, required 0x%0h", bus.MEM_ADDRESS, ea);
                        end
                    end
                end
                if (busy_cnt < mem_lat) begin
                    busy_cnt++;
                    bus.MEM_BUSYWAIT = 1'b1;
                    bus.MEM_READDATA = {4{32'hDEAD_BEEF}};
                end else begin
                    bus.MEM_BUSYWAIT = 1'b0;
                    bus.MEM_READDATA = block_of(bus.MEM_ADDRESS);
                end
            end else begin
                in_req = 0;
                bus.MEM_BUSYWAIT = 1'b0;
                bus.MEM_READDATA = {4{32'hDEAD_BEEF}};
            end
        end
    end

    // One fetch: present pc, follow the stall if any, compare the returned instruction
    task automatic fetch(input logic [31:0] pc, input bit exp_miss, input logic [5:0] exp_addr, input int lat);
        int cyc;
        int rd_cycles;
        logic [31:0] ei;
        exp_q.push_back(pc & 32'h0000_03FC);
        if (exp_miss) addr_q.push_back(exp_addr);
        mem_lat = lat;
        @(negedge CLK);
        RESET = 1'b0;
        bus.PC = pc;
        #1;
        checks++;
        if (bus.BUSYWAIT !== exp_miss) begin
            errors++;
            $display("FAIL first_busywait pc=0x%0h: got %b, required %b", pc, bus.BUSYWAIT, exp_miss);
        end
        if (!exp_miss) begin
            checks++;
            if (bus.MEM_READ !== 1'b0) begin
                errors++;
                $display("FAIL hit_mem_read pc=0x%0h: got %b, required 0", pc, bus.MEM_READ);
            end
        end
        cyc = 0;
        rd_cycles = 0;
        while (bus.BUSYWAIT !== 1'b0 && cyc < 50) begin
            @(negedge CLK);
            #1;
            cyc++;
            if (bus.MEM_READ === 1'b1) rd_cycles++;
        end
        checks++;
        if (cyc >= 50) begin
            errors++;
            $display("FAIL stall_timeout pc=0x%0h: busywait still %b after %0d cycles, required 0", pc, bus.BUSYWAIT, cyc);
        end
        ei = exp_q.pop_front();
        checks++;
        if (bus.INSTRUCTION !== ei) begin
            errors++;
            $display("FAIL instruction pc=0x%0h: got 0x%0h, required 0x%0h", pc, bus.INSTRUCTION, ei);
        end
        if (exp_miss) begin
            checks++;
            if (rd_cycles != lat + 1) begin
                errors++;
                $display("FAIL mem_read_cycles pc=0x%0h: got %0d, required %0d", pc, rd_cycles, lat + 1);
            end
            checks++;
            if (cyc != lat + 3) begin
                errors++;
                $display("FAIL miss_latency pc=0x%0h: got %0d, required %0d", pc, cyc, lat + 3);
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.PC = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            #1;
            checks++;
            if (bus.BUSYWAIT !== 1'b1 || bus.MEM_READ !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: busywait=%b mem_read=%b, required 1 and 0", i, bus.BUSYWAIT, bus.MEM_READ);
            end
        end
    endtask

    task automatic test_cold_miss();
        fetch(32'h000, 1, 6'h00, 3);
    endtask

    task automatic test_sequential_hits();
        fetch(32'h004, 0, 6'h00, 0);
        fetch(32'h008, 0, 6'h00, 0);
        fetch(32'h00C, 0, 6'h00, 0);
    endtask

    task automatic test_zero_latency();
        fetch(32'h010, 1, 6'h01, 0);
    endtask

    task automatic test_back_to_back();
        fetch(32'h00C, 0, 6'h00, 0);
        fetch(32'h010, 0, 6'h00, 0);
        fetch(32'h014, 0, 6'h00, 0);
        fetch(32'h008, 0, 6'h00, 0);
    endtask

    task automatic test_conflict();
        fetch(32'h080, 1, 6'h08, 2);
        fetch(32'h084, 0, 6'h00, 0);
        fetch(32'h000, 1, 6'h00, 1);
        fetch(32'h01C, 0, 6'h00, 0);
    endtask

    task automatic test_reset_mid_fill();
        int cyc;
        logic [31:0] ei;
        mem_lat = 20;
        addr_q.push_back(6'h02);
        @(negedge CLK);
        RESET = 1'b0;
        bus.PC = 32'h020;
        #1;
        checks++;
        if (bus.BUSYWAIT !== 1'b1) begin
            errors++;
            $display("FAIL rmf_miss: busywait got %b, required 1", bus.BUSYWAIT);
        end
        @(negedge CLK);
        #1;
        checks++;
        if (bus.MEM_READ !== 1'b1) begin
            errors++;
            $display("FAIL rmf_request: mem_read got %b, required 1", bus.MEM_READ);
        end
        @(negedge CLK);
        RESET = 1'b1;
        mem_lat = 1;
        #1;
        checks++;
        if (bus.MEM_READ !== 1'b0 || bus.BUSYWAIT !== 1'b1) begin
            errors++;
            $display("FAIL rmf_during_reset: mem_read=%b busywait=%b, required 0 and 1", bus.MEM_READ, bus.BUSYWAIT);
        end
        addr_q.push_back(6'h02);
        exp_q.push_back(32'h020);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        checks++;
        if (bus.MEM_READ !== 1'b0 || bus.BUSYWAIT !== 1'b1) begin
            errors++;
            $display("FAIL rmf_after_reset: mem_read=%b busywait=%b, required 0 and 1", bus.MEM_READ, bus.BUSYWAIT);
        end
        cyc = 0;
        while (bus.BUSYWAIT !== 1'b0 && cyc < 50) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL rmf_refill_latency: got %0d cycles, required 4", cyc);
        end
        ei = exp_q.pop_front();
        checks++;
        if (bus.INSTRUCTION !== ei) begin
            errors++;
            $display("FAIL rmf_instruction: got 0x%0h, required 0x%0h", bus.INSTRUCTION, ei);
        end
        // Reset also dropped line 0, which was valid before
        fetch(32'h000, 1, 6'h00, 0);
    endtask

    task automatic test_pc_change();
        int cyc;
        int rd_cycles;
        logic [31:0] ei;
        mem_lat = 2;
        addr_q.push_back(6'h03);
        addr_q.push_back(6'h04);
        exp_q.push_back(32'h040);
        @(negedge CLK);
        RESET = 1'b0;
        bus.PC = 32'h030;
        #1;
        checks++;
        if (bus.BUSYWAIT !== 1'b1) begin
            errors++;
            $display("FAIL pcc_miss: busywait got %b, required 1", bus.BUSYWAIT);
        end
        @(negedge CLK);
        #1;
        rd_cycles = (bus.MEM_READ === 1'b1) ? 1 : 0;
        bus.PC = 32'h040;
        cyc = 1;
        while (bus.BUSYWAIT !== 1'b0 && cyc < 60) begin
            @(negedge CLK);
            #1;
            cyc++;
            if (bus.MEM_READ === 1'b1) rd_cycles++;
        end
        checks++;
        if (cyc != 10) begin
            errors++;
            $display("FAIL pcc_latency: got %0d cycles, required 10", cyc);
        end
        checks++;
        if (rd_cycles != 6) begin
            errors++;
            $display("FAIL pcc_mem_read_cycles: got %0d, required 6", rd_cycles);
        end
        ei = exp_q.pop_front();
        checks++;
        if (bus.INSTRUCTION !== ei) begin
            errors++;
            $display("FAIL pcc_instruction: got 0x%0h, required 0x%0h", bus.INSTRUCTION, ei);
        end
        fetch(32'h034, 0, 6'h00, 0);
        fetch(32'h048, 0, 6'h00, 0);
        checks++;
        if (addr_q.size() != 0) begin
            errors++;
            $display("FAIL pcc_requests: %0d expected requests never issued, required 0", addr_q.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mem_lat = 0;
        RESET = 1'b1;
        bus.PC = 32'h0;
        test_reset();
        test_cold_miss();
        test_sequential_hits();
        test_zero_latency();
        test_back_to_back();
        test_conflict();
        test_reset_mid_fill();
        test_pc_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
